id_pipe: RTL and testbench

ID_PIPE -- requirements
Module: id_pipe

---
 rtl/id_pipe_pkg.sv | 36 +++
 rtl/id_pipe_if.sv | 47 ++++
 rtl/id_fwd_mux.sv | 29 ++
 rtl/id_pipe.sv | 159 +++++++++++++++
 tb/tb_id_pipe.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_pipe_pkg.sv
// rtl/id_pipe_pkg.sv - opcode/funct constants, ALU encodings and operand-source selectors for id_pipe
package id_pipe_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [7:0] ALU_OP_NOP = 8'h00;
  localparam logic [7:0] ALU_OP_AND = 8'h24;
  localparam logic [7:0] ALU_OP_OR  = 8'h25;
  localparam logic [7:0] ALU_OP_XOR = 8'h26;
  localparam logic [7:0] ALU_OP_NOR = 8'h27;
  localparam logic [7:0] ALU_OP_SLL = 8'h7C;
  localparam logic [7:0] ALU_OP_SRL = 8'h02;
  localparam logic [7:0] ALU_OP_SRA = 8'h03;

  localparam logic [2:0] ALU_SEL_NOP   = 3'b000;
  localparam logic [2:0] ALU_SEL_LOGIC = 3'b001;
  localparam logic [2:0] ALU_SEL_SHIFT = 3'b010;

  typedef enum logic [1:0] {OP1_ZERO, OP1_RS, OP1_IMM_HI, OP1_SA} op1_src_e;
  typedef enum logic [1:0] {OP2_ZERO, OP2_RT, OP2_IMM} op2_src_e;

endpackage

// File: rtl/id_pipe_if.sv
// rtl/id_pipe_if.sv - IF/ID, register-file, bypass and ID/EX signal bundle of id_pipe
interface id_pipe_if
  import id_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic                  in_valid, in_ready;
  logic [31:0]           pc_i, inst_i;
  logic                  reg1_read_en_o, reg2_read_en_o;
  logic [REG_ADDR_W-1:0] reg1_read_addr_o, reg2_read_addr_o;
  logic [DATA_W-1:0]     reg1_data_i, reg2_data_i;
  logic                  ex_wreg_en_i, ex_is_load_i;
  logic [REG_ADDR_W-1:0] ex_wreg_addr_i;
  logic [DATA_W-1:0]     ex_wdata_i;
  logic                  mem_wreg_en_i;
  logic [REG_ADDR_W-1:0] mem_wreg_addr_i;
  logic [DATA_W-1:0]     mem_wdata_i;
  logic                  flush_i;
  logic                  out_valid, out_ready;
  logic [7:0]            alu_op_o;
  logic [2:0]            alu_sel_o;
  logic [DATA_W-1:0]     op_number_1_o, op_number_2_o;
  logic                  write_reg_en_o;
  logic [REG_ADDR_W-1:0] write_reg_addr_o;
  logic [31:0]           pc_o;
  logic                  inst_invalid_o;
  logic [CNT_W-1:0]      stall_cnt_o;

  modport slave (
    input  in_valid, pc_i, inst_i, reg1_data_i, reg2_data_i,
           ex_wreg_en_i, ex_wreg_addr_i, ex_wdata_i, ex_is_load_i,
           mem_wreg_en_i, mem_wreg_addr_i, mem_wdata_i, flush_i, out_ready,
    output in_ready, reg1_read_en_o, reg2_read_en_o, reg1_read_addr_o, reg2_read_addr_o,
           out_valid, alu_op_o, alu_sel_o, op_number_1_o, op_number_2_o,
           write_reg_en_o, write_reg_addr_o, pc_o, inst_invalid_o, stall_cnt_o
  );

  modport master (
    output in_valid, pc_i, inst_i, reg1_data_i, reg2_data_i,
           ex_wreg_en_i, ex_wreg_addr_i, ex_wdata_i, ex_is_load_i,
           mem_wreg_en_i, mem_wreg_addr_i, mem_wdata_i, flush_i, out_ready,
    input  in_ready, reg1_read_en_o, reg2_read_en_o, reg1_read_addr_o, reg2_read_addr_o,
           out_valid, alu_op_o, alu_sel_o, op_number_1_o, op_number_2_o,
           write_reg_en_o, write_reg_addr_o, pc_o, inst_invalid_o, stall_cnt_o
  );
endinterface

// File: rtl/id_fwd_mux.sv
// rtl/id_fwd_mux.sv - selects one source operand from EX, MEM or the register file
module id_fwd_mux
  import id_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic                  ex_en,
  input  logic [REG_ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0]     ex_data,
  input  logic                  mem_en,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic [DATA_W-1:0]     src_data
);
  // $0 is hardwired, so a pending write to it must never shadow the file value
  always_comb begin
    src_data = rf_data;
    if (FWD_EN && (src_addr != '0)) begin
      if (ex_en && (ex_addr == src_addr)) begin
        src_data = ex_data;
      end else if (mem_en && (mem_addr == src_addr)) begin
        src_data = mem_data;
      end
    end
  end
endmodule

// File: rtl/id_pipe.sv
// rtl/id_pipe.sv - instruction decode stage with bypassing, load-use bubbles and a registered ID/EX slot
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input logic      clk,
  input logic      rst_n,
  id_pipe_if.slave bus
);
  logic [5:0]            opcode, funct;
  logic [REG_ADDR_W-1:0] rs, rt, rd, dec_waddr;
  logic                  is_imm, is_lui, is_rlog, is_shift, dec_inv, rd1_en, rd2_en, hazard;
  logic [7:0]            dec_op;
  logic [2:0]            dec_sel;
  op1_src_e              op1_src;
  op2_src_e              op2_src;
  logic [DATA_W-1:0]     rs_val, rt_val, op1_val, op2_val;
  logic                  upd, take;

  logic                  out_valid_q, out_valid_d, wreg_en_q, wreg_en_d, inv_q, inv_d;
  logic [7:0]            alu_op_q, alu_op_d;
  logic [2:0]            alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0]     op1_q, op1_d, op2_q, op2_d;
  logic [REG_ADDR_W-1:0] wreg_addr_q, wreg_addr_d;
  logic [31:0]           pc_q, pc_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  assign opcode   = bus.inst_i[31:26];
  assign funct    = bus.inst_i[5:0];
  assign rs       = bus.inst_i[25:21];
  assign rt       = bus.inst_i[20:16];
  assign rd       = bus.inst_i[15:11];
  assign is_imm   = opcode inside {OP_ANDI, OP_ORI, OP_XORI};
  assign is_lui   = (opcode == OP_LUI);
  assign is_rlog  = (opcode == OP_SPECIAL) && (funct inside {FN_AND, FN_OR, FN_XOR, FN_NOR});
  assign is_shift = (opcode == OP_SPECIAL) && (funct inside {FN_SLL, FN_SRL, FN_SRA});
  assign dec_inv  = !(is_imm | is_lui | is_rlog | is_shift);
  assign rd1_en   = is_imm | is_rlog;
  assign rd2_en   = is_rlog | is_shift;

  always_comb begin
    dec_op = ALU_OP_NOP;
    case (opcode)
      OP_ANDI:        dec_op = ALU_OP_AND;
      OP_ORI, OP_LUI: dec_op = ALU_OP_OR;
      OP_XORI:        dec_op = ALU_OP_XOR;
      OP_SPECIAL: begin
        case (funct)
          FN_AND:  dec_op = ALU_OP_AND;
          FN_OR:   dec_op = ALU_OP_OR;
          FN_XOR:  dec_op = ALU_OP_XOR;
          FN_NOR:  dec_op = ALU_OP_NOR;
          FN_SLL:  dec_op = ALU_OP_SLL;
          FN_SRL:  dec_op = ALU_OP_SRL;
          FN_SRA:  dec_op = ALU_OP_SRA;
          default: dec_op = ALU_OP_NOP;
        endcase
      end
      default: dec_op = ALU_OP_NOP;
    endcase
  end

  always_comb begin
    dec_sel   = ALU_SEL_NOP;
    dec_waddr = '0;
    op1_src   = OP1_ZERO;
    op2_src   = OP2_ZERO;
    if (is_imm) begin
      dec_sel = ALU_SEL_LOGIC; dec_waddr = rt; op1_src = OP1_RS; op2_src = OP2_IMM;
    end else if (is_lui) begin
      dec_sel = ALU_SEL_LOGIC; dec_waddr = rt; op1_src = OP1_IMM_HI;
    end else if (is_rlog) begin
      dec_sel = ALU_SEL_LOGIC; dec_waddr = rd; op1_src = OP1_RS; op2_src = OP2_RT;
    end else if (is_shift) begin
      dec_sel = ALU_SEL_SHIFT; dec_waddr = rd; op1_src = OP1_SA; op2_src = OP2_RT;
    end
  end

  id_fwd_mux #(.DATA_W(DATA_W), .FWD_EN(FWD_EN)) u_fwd_rs (
    .src_addr(rs), .rf_data(bus.reg1_data_i),
    .ex_en(bus.ex_wreg_en_i), .ex_addr(bus.ex_wreg_addr_i), .ex_data(bus.ex_wdata_i),
    .mem_en(bus.mem_wreg_en_i), .mem_addr(bus.mem_wreg_addr_i), .mem_data(bus.mem_wdata_i),
    .src_data(rs_val)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .FWD_EN(FWD_EN)) u_fwd_rt (
    .src_addr(rt), .rf_data(bus.reg2_data_i),
    .ex_en(bus.ex_wreg_en_i), .ex_addr(bus.ex_wreg_addr_i), .ex_data(bus.ex_wdata_i),
    .mem_en(bus.mem_wreg_en_i), .mem_addr(bus.mem_wreg_addr_i), .mem_data(bus.mem_wdata_i),
    .src_data(rt_val)
  );

  always_comb begin
    case (op1_src)
      OP1_RS:     op1_val = rs_val;
      OP1_IMM_HI: op1_val = DATA_W'({bus.inst_i[15:0], 16'h0000});
      OP1_SA:     op1_val = DATA_W'(bus.inst_i[10:6]);
      default:    op1_val = '0;
    endcase
    case (op2_src)
      OP2_RT:  op2_val = rt_val;
      OP2_IMM: op2_val = DATA_W'(bus.inst_i[15:0]);
      default: op2_val = '0;
    endcase
  end

  // a load's data only exists after MEM, so a consumer must wait one slot
  assign hazard = bus.ex_is_load_i && bus.ex_wreg_en_i && (bus.ex_wreg_addr_i != '0) &&
                  ((rd1_en && (bus.ex_wreg_addr_i == rs)) || (rd2_en && (bus.ex_wreg_addr_i == rt)));

  assign upd  = bus.out_ready || !out_valid_q;
  assign take = upd && bus.in_valid && !hazard && !bus.flush_i;

  always_comb begin
    out_valid_d = bus.flush_i ? 1'b0 : (upd ? (bus.in_valid && !hazard) : out_valid_q);
    alu_op_d    = take ? dec_op    : alu_op_q;
    alu_sel_d   = take ? dec_sel   : alu_sel_q;
    op1_d       = take ? op1_val   : op1_q;
    op2_d       = take ? op2_val   : op2_q;
    wreg_en_d   = take ? !dec_inv  : wreg_en_q;
    wreg_addr_d = take ? dec_waddr : wreg_addr_q;
    pc_d        = take ? bus.pc_i  : pc_q;
    inv_d       = take ? dec_inv   : inv_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.in_valid && hazard && !bus.flush_i && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0; alu_op_q <= '0; alu_sel_q <= '0; op1_q <= '0; op2_q <= '0;
      wreg_en_q <= 1'b0; wreg_addr_q <= '0; pc_q <= '0; inv_q <= 1'b0; stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d; alu_op_q <= alu_op_d; alu_sel_q <= alu_sel_d;
      op1_q <= op1_d; op2_q <= op2_d; wreg_en_q <= wreg_en_d; wreg_addr_q <= wreg_addr_d;
      pc_q <= pc_d; inv_q <= inv_d; stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.in_ready         = upd && !hazard && !bus.flush_i;
  assign bus.reg1_read_en_o   = rd1_en;
  assign bus.reg2_read_en_o   = rd2_en;
  assign bus.reg1_read_addr_o = rs;
  assign bus.reg2_read_addr_o = rt;
  assign bus.out_valid        = out_valid_q;
  assign bus.alu_op_o         = alu_op_q;
  assign bus.alu_sel_o        = alu_sel_q;
  assign bus.op_number_1_o    = op1_q;
  assign bus.op_number_2_o    = op2_q;
  assign bus.write_reg_en_o   = wreg_en_q;
  assign bus.write_reg_addr_o = wreg_addr_q;
  assign bus.pc_o             = pc_q;
  assign bus.inst_invalid_o   = inv_q;
  assign bus.stall_cnt_o      = stall_cnt_q;
endmodule

// File: tb/tb_id_pipe.sv
// tb/tb_id_pipe.sv - random and directed checking of id_pipe against a behavioural decode model
module tb_id_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, ex_en, ex_load, mem_en, flush, out_ready;
  logic [31:0] pc, inst, ex_data, mem_data;
  logic [4:0]  ex_addr, mem_addr;
  logic [31:0] rf [32];

  id_pipe_if #(.DATA_W(32), .CNT_W(16)) b0 ();
  id_pipe_if #(.DATA_W(32), .CNT_W(3))  b1 ();

  id_pipe #(.DATA_W(32), .FWD_EN(1'b1), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  id_pipe #(.DATA_W(32), .FWD_EN(1'b0), .CNT_W(3))  dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  assign b0.in_valid = in_valid;        assign b1.in_valid = in_valid;
  assign b0.pc_i = pc;                  assign b1.pc_i = pc;
  assign b0.inst_i = inst;              assign b1.inst_i = inst;
  assign b0.ex_wreg_en_i = ex_en;       assign b1.ex_wreg_en_i = ex_en;
  assign b0.ex_wreg_addr_i = ex_addr;   assign b1.ex_wreg_addr_i = ex_addr;
  assign b0.ex_wdata_i = ex_data;       assign b1.ex_wdata_i = ex_data;
  assign b0.ex_is_load_i = ex_load;     assign b1.ex_is_load_i = ex_load;
  assign b0.mem_wreg_en_i = mem_en;     assign b1.mem_wreg_en_i = mem_en;
  assign b0.mem_wreg_addr_i = mem_addr; assign b1.mem_wreg_addr_i = mem_addr;
  assign b0.mem_wdata_i = mem_data;     assign b1.mem_wdata_i = mem_data;
  assign b0.flush_i = flush;            assign b1.flush_i = flush;
  assign b0.out_ready = out_ready;      assign b1.out_ready = out_ready;
  assign b0.reg1_data_i = rf[b0.reg1_read_addr_o];
  assign b0.reg2_data_i = rf[b0.reg2_read_addr_o];
  assign b1.reg1_data_i = rf[b1.reg1_read_addr_o];
  assign b1.reg2_data_i = rf[b1.reg2_read_addr_o];

  typedef struct {
    logic        inv, wen, urs, urt;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [4:0]  wa;
    logic [31:0] o1, o2, o1n, o2n;
  } dec_t;

  logic        m_valid, m_wen, m_inv;
  logic [7:0]  m_op;
  logic [2:0]  m_sel;
  logic [4:0]  m_wa;
  logic [31:0] m_o1, m_o2, m_o1n, m_o2n, m_pc;
  int          m_cnt0, m_cnt1;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] srcv(input logic [4:0] a, input bit fwd);
    if (fwd && a != 5'd0 && ex_en && ex_addr == a) return ex_data;
    if (fwd && a != 5'd0 && mem_en && mem_addr == a) return mem_data;
    return rf[a];
  endfunction

  function automatic dec_t mdec(input logic [31:0] w);
    dec_t d;
    logic [5:0] opc, fn;
    logic [4:0] rs, rt, rd;
    opc = w[31:26]; fn = w[5:0]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
    d.inv = 1'b1; d.wen = 1'b0; d.urs = 1'b0; d.urt = 1'b0; d.op = 8'h0; d.sel = 3'd0;
    d.wa = 5'd0; d.o1 = 32'h0; d.o2 = 32'h0; d.o1n = 32'h0; d.o2n = 32'h0;
    if (opc >= 6'd12 && opc <= 6'd14) begin
      d.op = 8'h24 + 8'(opc - 6'd12); d.sel = 3'd1; d.wa = rt; d.urs = 1'b1;
      d.o1 = srcv(rs, 1'b1); d.o1n = rf[rs]; d.o2 = {16'h0, w[15:0]}; d.o2n = d.o2;
    end else if (opc == 6'd15) begin
      d.op = 8'h25; d.sel = 3'd1; d.wa = rt; d.o1 = {w[15:0], 16'h0}; d.o1n = d.o1;
    end else if (opc == 6'd0 && fn >= 6'd36 && fn <= 6'd39) begin
      d.op = 8'h24 + 8'(fn - 6'd36); d.sel = 3'd1; d.wa = rd; d.urs = 1'b1; d.urt = 1'b1;
      d.o1 = srcv(rs, 1'b1); d.o1n = rf[rs]; d.o2 = srcv(rt, 1'b1); d.o2n = rf[rt];
    end else if (opc == 6'd0 && (fn == 6'd0 || fn == 6'd2 || fn == 6'd3)) begin
      d.op = (fn == 6'd0) ? 8'h7C : {2'b00, fn}; d.sel = 3'd2; d.wa = rd; d.urt = 1'b1;
      d.o1 = {27'h0, w[10:6]}; d.o1n = d.o1; d.o2 = srcv(rt, 1'b1); d.o2n = rf[rt];
    end
    if (d.sel != 3'd0) begin d.inv = 1'b0; d.wen = 1'b1; end
    return d;
  endfunction

  task automatic compare_outs();
    chk("out_valid", 32'(b0.out_valid), 32'(m_valid));
    chk("out_valid_nofwd", 32'(b1.out_valid), 32'(m_valid));
    chk("stall_cnt", 32'(b0.stall_cnt_o), 32'(m_cnt0));
    chk("stall_cnt_3b", 32'(b1.stall_cnt_o), 32'(m_cnt1));
    if (m_valid) begin
      chk("alu_op", 32'(b0.alu_op_o), 32'(m_op));
      chk("alu_sel", 32'(b0.alu_sel_o), 32'(m_sel));
      chk("op1", b0.op_number_1_o, m_o1);
      chk("op2", b0.op_number_2_o, m_o2);
      chk("wreg_en", 32'(b0.write_reg_en_o), 32'(m_wen));
      chk("wreg_addr", 32'(b0.write_reg_addr_o), 32'(m_wa));
      chk("pc", b0.pc_o, m_pc);
      chk("inst_invalid", 32'(b0.inst_invalid_o), 32'(m_inv));
      chk("op1_nofwd", b1.op_number_1_o, m_o1n);
      chk("op2_nofwd", b1.op_number_2_o, m_o2n);
    end
  endtask

  // one clock: check combinational handshake, advance the model, then check registered outputs
  task automatic cycle();
    dec_t d;
    bit hz, upd;
    #1;
    d   = mdec(inst);
    hz  = ex_load && ex_en && ex_addr != 5'd0 &&
          ((d.urs && ex_addr == inst[25:21]) || (d.urt && ex_addr == inst[20:16]));
    upd = out_ready || !m_valid;
    chk("in_ready", 32'(b0.in_ready), 32'(upd && !hz && !flush));
    chk("in_ready_nofwd", 32'(b1.in_ready), 32'(upd && !hz && !flush));
    if (in_valid) begin
      chk("rd1_en", 32'(b0.reg1_read_en_o), 32'(d.urs));
      chk("rd2_en", 32'(b0.reg2_read_en_o), 32'(d.urt));
    end
    if (flush) m_valid = 1'b0;
    else if (upd) begin
      m_valid = in_valid && !hz;
      if (m_valid) begin
        m_op = d.op; m_sel = d.sel; m_o1 = d.o1; m_o2 = d.o2; m_o1n = d.o1n; m_o2n = d.o2n;
        m_wen = d.wen; m_wa = d.wa; m_pc = pc; m_inv = d.inv;
      end
    end
    if (in_valid && hz && !flush) begin
      if (m_cnt0 < 65535) m_cnt0++;
      if (m_cnt1 < 7) m_cnt1++;
    end
    @(posedge clk);
    #1;
    compare_outs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(b0.out_valid), 32'h0);
    chk("rst_wen", 32'(b0.write_reg_en_o), 32'h0);
    chk("rst_inv", 32'(b0.inst_invalid_o), 32'h0);
    chk("rst_alu_op", 32'(b0.alu_op_o), 32'h0);
    chk("rst_alu_sel", 32'(b0.alu_sel_o), 32'h0);
    chk("rst_op1", b0.op_number_1_o, 32'h0);
    chk("rst_op2", b0.op_number_2_o, 32'h0);
    chk("rst_waddr", 32'(b0.write_reg_addr_o), 32'h0);
    chk("rst_pc", b0.pc_o, 32'h0);
    chk("rst_cnt", 32'(b0.stall_cnt_o), 32'h0);
    chk("rst_valid_nofwd", 32'(b1.out_valid), 32'h0);
    chk("rst_cnt_3b", 32'(b1.stall_cnt_o), 32'h0);
    m_valid = 1'b0; m_op = 8'h0; m_sel = 3'd0; m_o1 = 32'h0; m_o2 = 32'h0; m_o1n = 32'h0;
    m_o2n = 32'h0; m_wen = 1'b0; m_wa = 5'd0; m_pc = 32'h0; m_inv = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int k;
    w = $urandom;
    w[25:21] = 5'($urandom_range(7));
    w[20:16] = 5'($urandom_range(7));
    w[15:11] = 5'($urandom_range(7));
    k = $urandom_range(11);
    if (k <= 3) w[31:26] = 6'd12 + 6'(k);
    else if (k <= 7) begin w[31:26] = 6'd0; w[5:0] = 6'd36 + 6'(k - 4); end
    else if (k == 8) begin w[31:26] = 6'd0; w[5:0] = 6'd0; end
    else if (k == 9) begin w[31:26] = 6'd0; w[5:0] = 6'd2; end
    else if (k == 10) begin w[31:26] = 6'd0; w[5:0] = 6'd3; end
    return w;
  endfunction

  initial begin
    in_valid = 0; ex_en = 0; ex_load = 0; mem_en = 0; flush = 0; out_ready = 0;
    pc = 0; inst = 0; ex_data = 0; mem_data = 0; ex_addr = 0; mem_addr = 0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'h0;
    #2;
    do_reset();

    // ORI $2,$1,0x00F0
    rf[1] = 32'h12340000; rf[2] = 32'h00000005;
    in_valid = 1; out_ready = 1; inst = 32'h342200F0; pc = 32'h100;
    cycle();
    chk("ori_op1", b0.op_number_1_o, 32'h12340000);
    chk("ori_op2", b0.op_number_2_o, 32'h000000F0);
    chk("ori_alu_op", 32'(b0.alu_op_o), 32'h25);
    chk("ori_dest", 32'(b0.write_reg_addr_o), 32'd2);

    // OR $3,$1,$2 with EX and MEM both writing $1
    inst = 32'h00221825; pc = 32'h104;
    ex_en = 1; ex_addr = 5'd1; ex_data = 32'hAAAA0000; mem_en = 1; mem_addr = 5'd1; mem_data = 32'h1;
    cycle();
    chk("or_fwd_op1", b0.op_number_1_o, 32'hAAAA0000);
    chk("or_nofwd_op1", b1.op_number_1_o, 32'h12340000);
    chk("or_op2", b0.op_number_2_o, 32'h5);

    // load in EX to $4, OR $5,$4,$2 in ID
    ex_addr = 5'd4; ex_load = 1; mem_en = 0; inst = 32'h00822825; pc = 32'h108;
    #1 chk("lu_in_ready", 32'(b0.in_ready), 32'h0);
    cycle();
    chk("lu_bubble", 32'(b0.out_valid), 32'h0);
    chk("lu_cnt", 32'(b0.stall_cnt_o), 32'd1);
    ex_en = 0; ex_load = 0; mem_en = 1; mem_addr = 5'd4; mem_data = 32'hDEAD0004;
    #1 chk("lu_resume_ready", 32'(b0.in_ready), 32'h1);
    cycle();
    chk("lu_fwd_valid", 32'(b0.out_valid), 32'h1);
    chk("lu_fwd_op1", b0.op_number_1_o, 32'hDEAD0004);

    // downstream stall then flush
    out_ready = 0; inst = 32'h342200F0; pc = 32'h10C;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_in_ready", 32'(b0.in_ready), 32'h0);
      cycle();
      chk("hold_op1", b0.op_number_1_o, 32'hDEAD0004);
      chk("hold_pc", b0.pc_o, 32'h108);
    end
    flush = 1;
    cycle();
    chk("flush_valid", 32'(b0.out_valid), 32'h0);
    flush = 0;

    // unrecognised instruction, then reset mid-stream
    out_ready = 1; inst = 32'hFC000000; pc = 32'h110;
    cycle();
    chk("inv_flag", 32'(b0.inst_invalid_o), 32'h1);
    chk("inv_wen", 32'(b0.write_reg_en_o), 32'h0);
    do_reset();

    // sustained load-use stalls saturate the narrow counter
    mem_en = 0; ex_en = 1; ex_load = 1; ex_addr = 5'd4; inst = 32'h00822825;
    for (int i = 0; i < 10; i++) cycle();
    chk("sat_cnt_3b", 32'(b1.stall_cnt_o), 32'd7);
    chk("sat_cnt_16b", 32'(b0.stall_cnt_o), 32'd10);

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(9) < 8);
      out_ready = ($urandom_range(9) < 7);
      flush     = ($urandom_range(29) == 0);
      inst      = rand_inst();
      pc        = $urandom;
      ex_en     = 1'($urandom_range(1));
      ex_addr   = 5'($urandom_range(7));
      ex_data   = $urandom;
      ex_load   = ($urandom_range(2) == 0);
      mem_en    = 1'($urandom_range(1));
      mem_addr  = 5'($urandom_range(7));
      mem_data  = $urandom;
      rf[$urandom_range(1, 7)] = $urandom;
      if ($urandom_range(499) == 0) do_reset();
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
